// File: rtl/fht_control_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fht_control_if : start/status and bank-addressing bundle of fht_control    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface fht_control_if #(
    parameter int A_BIT = 8
);
    logic             iSTART;
    logic             oST_ZERO;
    logic             oST_LAST;
    logic             o2ND_PART_SUBSEC;
    logic [1:0]       oSECTOR;
    logic [A_BIT-1:0] oADDR_RD_0;
    logic [A_BIT-1:0] oADDR_RD_1;
    logic [A_BIT-1:0] oADDR_RD_2;
    logic [A_BIT-1:0] oADDR_RD_3;
    logic [A_BIT-1:0] oADDR_WR_0;
    logic [A_BIT-1:0] oADDR_WR_1;
    logic [A_BIT-1:0] oADDR_WR_2;
    logic [A_BIT-1:0] oADDR_WR_3;
    logic [A_BIT-1:0] oADDR_COEF;
    logic             oWE_A;
    logic             oWE_B;
    logic             oSOURCE_DATA;
    logic             oSOURCE_CONT;
    logic             oRDY;

    modport master (
        output iSTART,
        input  oST_ZERO, oST_LAST, o2ND_PART_SUBSEC, oSECTOR,
        input  oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
        input  oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
        input  oADDR_COEF, oWE_A, oWE_B, oSOURCE_DATA, oSOURCE_CONT, oRDY
    );

    modport slave (
        input  iSTART,
        output oST_ZERO, oST_LAST, o2ND_PART_SUBSEC, oSECTOR,
        output oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
        output oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
        output oADDR_COEF, oWE_A, oWE_B, oSOURCE_DATA, oSOURCE_CONT, oRDY
    );
endinterface
`default_nettype wire

// File: rtl/fht_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fht_control : stage/address sequencer for an in-place 4-bank radix-2 FHT   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fht_control #(
    parameter int A_BIT  = 8,
    parameter int LAT    = 3,
    parameter int STAGES = A_BIT + 2
) (
    input wire           iCLK,
    input wire           iRESET,
    fht_control_if.slave bus
);

    localparam int RD_CYCLES = 2 ** A_BIT;
    localparam int CNT_LAST  = RD_CYCLES + LAT - 1;
    localparam int CNT_W     = $clog2(CNT_LAST + 1);
    localparam int S_W       = $clog2(STAGES);

    localparam logic [S_W-1:0]   S_LAST     = S_W'(STAGES - 1);
    localparam logic [CNT_W-1:0] CNT_END    = CNT_W'(CNT_LAST);
    localparam logic [CNT_W-1:0] CNT_RD_END = CNT_W'(RD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_WE_BEG = CNT_W'(LAT);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [S_W-1:0]         stage_q, stage_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [3:0][A_BIT-1:0]  rd_q, rd_d;
    logic [3:0][A_BIT-1:0]  dly_q [LAT];
    logic [3:0][A_BIT-1:0]  dly_d [LAT];
    logic [A_BIT-1:0]       coef_q, coef_d;
    logic [1:0]             sector_q, sector_d;
    logic                   half_q, half_d;
    logic                   we_a_q, we_a_d;
    logic                   we_b_q, we_b_d;
    logic                   src_data_q, src_data_d;
    logic                   src_cont_q, src_cont_d;
    logic                   rdy_q, rdy_d;
    logic                   st_zero_q, st_zero_d;
    logic                   st_last_q, st_last_d;

    logic                   busy_d;
    logic                   we_en_d;
    logic [A_BIT-1:0]       t_rd;
    logic [A_BIT-1:0]       u_idx;
    logic [A_BIT-1:0]       bit_b;
    logic [A_BIT-1:0]       mask_b;
    logic [A_BIT-1:0]       base;
    logic [A_BIT-1:0]       partner;
    logic [S_W-1:0]         b_idx;

    // Sequencer: stage counter and per-stage cycle counter (read + drain)
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.iSTART) begin
                    state_d = ST_RUN;
                    stage_d = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == CNT_END) begin
                    cnt_d = '0;
                    if (stage_q == S_LAST) begin
                        state_d = ST_IDLE;
                        stage_d = '0;
                    end else begin
                        stage_d = stage_q + S_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // Outputs are computed from the next state so they leave the flops aligned
    always_comb begin
        busy_d  = (state_d == ST_RUN);
        t_rd    = (cnt_d >= CNT_RD_END) ? '1 : cnt_d[A_BIT-1:0];
        b_idx   = stage_d - S_W'(2);
        bit_b   = A_BIT'(1) << b_idx;
        mask_b  = bit_b - A_BIT'(1);
        u_idx   = {1'b0, t_rd[A_BIT-1:1]};
        base    = ((u_idx & ~mask_b) << 1) | (u_idx & mask_b);
        partner = base | bit_b;

        rd_d     = {4{t_rd}};
        coef_d   = '0;
        half_d   = 1'b0;
        sector_d = (stage_d == '0) ? 2'd0 : 2'd1;
        if (stage_d >= S_W'(2)) begin
            sector_d = 2'd2;
            half_d   = t_rd[0];
            coef_d   = (base & mask_b) << (A_BIT - 1 - int'(b_idx));
            rd_d     = t_rd[0] ? {base, base, partner, partner}
                               : {partner, partner, base, base};
        end

        // The counter never passes RD_CYCLES-1+LAT, so only the lower bound matters
        we_en_d    = busy_d && (cnt_d >= CNT_WE_BEG);
        we_a_d     = we_en_d && stage_d[0];
        we_b_d     = we_en_d && !stage_d[0];
        src_data_d = busy_d && stage_d[0];
        src_cont_d = busy_d;
        rdy_d      = !busy_d;
        st_zero_d  = busy_d && (stage_d == '0);
        st_last_d  = busy_d && (stage_d == S_LAST);

        dly_d[0] = rd_q;
        for (int i = 1; i < LAT; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q    <= ST_IDLE;
            stage_q    <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            coef_q     <= '0;
            sector_q   <= '0;
            half_q     <= 1'b0;
            we_a_q     <= 1'b0;
            we_b_q     <= 1'b0;
            src_data_q <= 1'b0;
            src_cont_q <= 1'b0;
            rdy_q      <= 1'b1;
            st_zero_q  <= 1'b0;
            st_last_q  <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            coef_q     <= coef_d;
            sector_q   <= sector_d;
            half_q     <= half_d;
            we_a_q     <= we_a_d;
            we_b_q     <= we_b_d;
            src_data_q <= src_data_d;
            src_cont_q <= src_cont_d;
            rdy_q      <= rdy_d;
            st_zero_q  <= st_zero_d;
            st_last_q  <= st_last_d;
            for (int i = 0; i < LAT; i++) begin
                dly_q[i] <= dly_d[i];
            end
        end
    end

    assign bus.oADDR_RD_0       = rd_q[0];
    assign bus.oADDR_RD_1       = rd_q[1];
    assign bus.oADDR_RD_2       = rd_q[2];
    assign bus.oADDR_RD_3       = rd_q[3];
    assign bus.oADDR_WR_0       = dly_q[LAT-1][0];
    assign bus.oADDR_WR_1       = dly_q[LAT-1][1];
    assign bus.oADDR_WR_2       = dly_q[LAT-1][2];
    assign bus.oADDR_WR_3       = dly_q[LAT-1][3];
    assign bus.oADDR_COEF       = coef_q;
    assign bus.oSECTOR          = sector_q;
    assign bus.o2ND_PART_SUBSEC = half_q;
    assign bus.oWE_A            = we_a_q;
    assign bus.oWE_B            = we_b_q;
    assign bus.oSOURCE_DATA     = src_data_q;
    assign bus.oSOURCE_CONT     = src_cont_q;
    assign bus.oRDY             = rdy_q;
    assign bus.oST_ZERO         = st_zero_q;
    assign bus.oST_LAST         = st_last_q;

endmodule
`default_nettype wire

// File: tb/tb_fht_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fht_control : randomized self-checking bench against a cycle model      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fht_control;

    localparam int A_BIT     = 8;
    localparam int LAT       = 3;
    localparam int STAGES    = A_BIT + 2;
    localparam int NPT       = 2 ** A_BIT;
    localparam int STAGE_LEN = NPT + LAT;
    localparam int RUN_LEN   = STAGES * STAGE_LEN;

    typedef struct packed {
        logic       rdy;
        logic       cont;
        logic       src;
        logic       we_a;
        logic       we_b;
        logic       zero;
        logic       last;
        logic       half;
        logic [1:0] sector;
    } ctrl_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass   = 0;
    int   n_checks = 0;
    bit   m_busy   = 1'b0;
    int   m_k      = 0;
    int   busy_cnt;
    int   last_cnt;
    int   stop_k;
    logic [4*A_BIT-1:0] hist [$];

    fht_control_if #(.A_BIT(A_BIT)) bus ();

    fht_control #(.A_BIT(A_BIT), .LAT(LAT), .STAGES(STAGES)) dut (
        .iCLK   (clk),
        .iRESET (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected outputs for run cycle k, straight from the stage/address rules
    function automatic void model(input bit busy, input int k, output ctrl_t c,
                                  output logic [4*A_BIT-1:0] rd, output logic [A_BIT-1:0] coef);
        int s, ts, t, b, u, lo, hi, base, partner;
        logic [A_BIT-1:0] a0, a1, a2, a3;
        c    = '0;
        rd   = '0;
        coef = '0;
        if (!busy) begin
            c.rdy = 1'b1;
            return;
        end
        s  = k / STAGE_LEN;
        ts = k % STAGE_LEN;
        t  = (ts < NPT) ? ts : NPT - 1;
        c.cont   = 1'b1;
        c.src    = (s % 2 == 1);
        c.zero   = (s == 0);
        c.last   = (s == STAGES - 1);
        c.sector = (s == 0) ? 2'd0 : ((s == 1) ? 2'd1 : 2'd2);
        c.we_a   = (ts >= LAT) && (ts <= NPT - 1 + LAT) && (s % 2 == 1);
        c.we_b   = (ts >= LAT) && (ts <= NPT - 1 + LAT) && (s % 2 == 0);
        if (s < 2) begin
            a0 = A_BIT'(t); a1 = A_BIT'(t); a2 = A_BIT'(t); a3 = A_BIT'(t);
        end else begin
            b       = s - 2;
            c.half  = (t % 2 == 1);
            u       = t / 2;
            lo      = u % (1 << b);
            hi      = u / (1 << b);
            base    = hi * (1 << (b + 1)) + lo;
            partner = base + (1 << b);
            coef    = A_BIT'((base % (1 << b)) * (1 << (A_BIT - 1 - b)));
            if (t % 2 == 0) begin
                a0 = A_BIT'(base); a1 = A_BIT'(base); a2 = A_BIT'(partner); a3 = A_BIT'(partner);
            end else begin
                a0 = A_BIT'(partner); a1 = A_BIT'(partner); a2 = A_BIT'(base); a3 = A_BIT'(base);
            end
        end
        rd = {a3, a2, a1, a0};
    endfunction

    task automatic clear_hist();
        hist.delete();
        for (int i = 0; i < LAT; i++) hist.push_back('0);
    endtask

    task automatic check_cycle(input string where, input bit use_hist);
        ctrl_t ce, cg;
        logic [4*A_BIT-1:0] rde, rdg, wre, wrg;
        logic [A_BIT-1:0] coef_e;
        model(m_busy, m_k, ce, rde, coef_e);
        wre = '0;
        if (use_hist) begin
            wre = hist.pop_front();
            hist.push_back(rde);
        end
        cg  = {bus.oRDY, bus.oSOURCE_CONT, bus.oSOURCE_DATA, bus.oWE_A, bus.oWE_B,
               bus.oST_ZERO, bus.oST_LAST, bus.o2ND_PART_SUBSEC, bus.oSECTOR};
        rdg = {bus.oADDR_RD_3, bus.oADDR_RD_2, bus.oADDR_RD_1, bus.oADDR_RD_0};
        wrg = {bus.oADDR_WR_3, bus.oADDR_WR_2, bus.oADDR_WR_1, bus.oADDR_WR_0};
        check_eq($sformatf("%s ctrl busy=%0d k=%0d", where, m_busy, m_k), 64'(cg), 64'(ce));
        check_eq($sformatf("%s rd k=%0d", where, m_k), 64'(rdg), 64'(rde));
        check_eq($sformatf("%s wr k=%0d", where, m_k), 64'(wrg), 64'(wre));
        check_eq($sformatf("%s coef k=%0d", where, m_k), 64'(bus.oADDR_COEF), 64'(coef_e));
    endtask

    // One clock: advance the model at the edge, compare at the falling edge
    task automatic step(input string where);
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 1'b0;
            m_k    = 0;
        end else if (m_busy) begin
            if (m_k == RUN_LEN - 1) begin
                m_busy = 1'b0;
                m_k    = 0;
            end else begin
                m_k++;
            end
        end else if (bus.iSTART) begin
            m_busy = 1'b1;
            m_k    = 0;
        end
        @(negedge clk);
        check_cycle(where, 1'b1);
    endtask

    initial begin
        rst_n      = 1'b1;
        bus.iSTART = 1'b0;
        clear_hist();
        #1 rst_n = 1'b0;
        #1 check_cycle("reset", 1'b0);
        repeat (3) begin
            bus.iSTART = 1'($urandom);
            step("in_reset");
        end
        bus.iSTART = 1'b0;
        rst_n      = 1'b1;
        repeat ($urandom_range(2, 6)) step("idle");

        // Full run with random iSTART noise while busy
        bus.iSTART = 1'b1;
        step("run1");
        bus.iSTART = 1'b0;
        busy_cnt = 0;
        last_cnt = 0;
        for (int cyc = 0; cyc < RUN_LEN + 50; cyc++) begin
            if (bus.oRDY) break;
            busy_cnt++;
            if (bus.oST_LAST) last_cnt++;
            bus.iSTART = (m_busy && m_k < RUN_LEN - 4) ? 1'($urandom) : 1'b0;
            step("run1");
        end
        bus.iSTART = 1'b0;
        check_eq("busy_len", 64'(busy_cnt), 64'(RUN_LEN));
        check_eq("last_stage_len", 64'(last_cnt), 64'(STAGE_LEN));
        repeat (5) step("idle1");

        // Second run, aborted by reset in the middle of stage 3
        bus.iSTART = 1'b1;
        step("run2");
        bus.iSTART = 1'b0;
        stop_k = 3 * STAGE_LEN + int'($urandom_range(10, 200));
        for (int cyc = 0; cyc < RUN_LEN; cyc++) begin
            if (m_k >= stop_k) break;
            bus.iSTART = 1'($urandom);
            step("run2");
        end
        bus.iSTART = 1'b0;
        check_eq("abort_point", 64'(m_k), 64'(stop_k));
        #2 rst_n = 1'b0;
        m_busy = 1'b0;
        m_k    = 0;
        clear_hist();
        #1 check_cycle("abort_rst", 1'b0);
        repeat (2) step("abort_hold");
        rst_n = 1'b1;
        repeat (20) step("post_abort_idle");

        // Restart after abort, run into stage 2
        bus.iSTART = 1'b1;
        step("run3");
        bus.iSTART = 1'b0;
        repeat (2 * STAGE_LEN + 40) begin
            bus.iSTART = 1'($urandom);
            step("run3");
        end
        bus.iSTART = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
